traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Parametrised N-approach traffic signal controller, successor to the fixed 2-way NS/EW toggler.
//  Cycles approaches through GREEN -> YELLOW -> ALL-RED, with programmable per-phase durations.
//  Adds a latched pedestrian WALK phase, optional skipping of idle approaches, and a run/freeze enable.
//  Sits between the sensor/button synchronisers and the lamp-driver outputs.
// PARAMETERS
//  NUM_DIR     2  number of approaches, 2..8
//  GREEN_CYC   8  cycles in GREEN, >=1
//  YELLOW_CYC  2  cycles in YELLOW, >=1
//  ALLRED_CYC  1  cycles in ALL-RED, >=1
//  WALK_CYC    4  cycles in WALK, >=1
//  SKIP_EMPTY  0  1 = jump to next approach with a pending vehicle request
//  CNT_W       8  phase counter width; every *_CYC must be <= 2**CNT_W
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  en          in   1        1 = run; 0 = freeze all state and outputs
//  veh_req     in   NUM_DIR  per-approach vehicle sensor, already synchronised
//  ped_req     in   1        pedestrian button, already synchronised; a single-cycle pulse suffices
//  green       out  NUM_DIR  one-hot green lamp, for the active approach in GREEN only
//  yellow      out  NUM_DIR  one-hot yellow lamp, for the active approach in YELLOW only
//  red         out  NUM_DIR  red lamp = ~(green|yellow)
//  walk        out  1        pedestrian walk lamp, 1 only in WALK
//  phase       out  2        current phase code
//  active_dir  out  DIR_W    active approach index; DIR_W = max(1, $clog2(NUM_DIR))
// BEHAVIOUR
//  - Moore machine. Outputs are decoded from registered state/dir only; no input-to-output path.
//  - State registers: phase, dir, cnt, ped_pend, veh_pend[NUM_DIR].
//  - Reset (rst=1 at a clock edge) gives phase=GREEN, dir=0, cnt=0, ped_pend=0, veh_pend=0.
//    Outputs after reset: green=1<<0, yellow=0, red=~1, walk=0, active_dir=0. rst overrides en.
//  - en=0: no register changes and no request latching; outputs hold.
//  - Counter: with en=1, cnt increments each cycle.
//    When cnt==DUR-1 (DUR = current phase duration): cnt<=0 and the phase advances on the same edge.
//  - Transitions:
//    GREEN -> YELLOW.
//    YELLOW -> ALLRED.
//    ALLRED -> WALK if ped_pend, else GREEN of next_dir.
//    WALK -> GREEN of next_dir. WALK is not followed by an extra ALL-RED.
//  - next_dir:
//    SKIP_EMPTY=0: (dir+1) mod NUM_DIR.
//    SKIP_EMPTY=1: first i in the cyclic order dir+1, dir+2, ... with veh_pend[i]=1.
//      The current dir is searched last. If no bit is set: (dir+1) mod NUM_DIR.
//  - veh_pend[i] is set when veh_req[i]=1 and en=1.
//    It is cleared on the edge where approach i enters GREEN. Clear wins over a simultaneous set.
//    veh_req[dir] asserted during dir's own GREEN sets veh_pend[dir] again after the entry edge.
//  - ped_pend is set when ped_req=1 and en=1, in any phase including WALK.
//    It is cleared on the edge entering WALK; clear wins over a simultaneous set.
//  - Safety invariants:
//    green|yellow has at most one bit set.
//    walk=1 implies green=yellow=0.
//    A change of dir always passes through YELLOW and then ALLRED or WALK.
//  - Phase encoding: GREEN=0, YELLOW=1, ALLRED=2, WALK=3.
//  - Mid-cycle reset returns to the reset state on the next edge and drops all pending requests.
// STRUCTURE
//  - traffic_pkg holds the phase encoding constants and the DIR_W computation macro/function.
//  - Sub-module traffic_rr_pick is combinational.
//    Inputs: veh_pend, dir, SKIP_EMPTY. Output: next_dir (cyclic priority search).
//  - Top holds the phase FSM, the counter, the request latches and the output decode.
//  - Elaboration checks: NUM_DIR in 2..8; every *_CYC in 1..2**CNT_W.
// TESTING (defaults unless stated; cycle 0 = first edge after rst deasserts)
//  1. Free run, no requests -> dir0 GREEN cycles 0-7, YELLOW 8-9, ALLRED 10.
//     dir1 GREEN at 11; dir0 GREEN again at 22 (period 22).
//  2. ped_req pulse at cycle 3 -> WALK cycles 11-14 with all lamps red, dir1 GREEN at 15.
//     ped_req at cycle 12 (in WALK) -> WALK served again after dir1's ALLRED.
//  3. SKIP_EMPTY=1, NUM_DIR=4; veh_req[2] pulse at cycle 2 -> next GREEN is dir2 at 11.
//     No pending requests -> dir3 follows dir2. veh_req[0] only -> wraps to dir0.
//  4. en=0 for cycles 8-12 (entering YELLOW) -> outputs and cnt frozen.
//     YELLOW then lasts 2 active cycles; requests pulsed while en=0 are ignored.
//  5. rst=1 at cycle 13 during WALK with ped_pend set -> cycle 14: dir0 GREEN, walk=0, all pends 0.
//  6. Random veh_req/ped_req/en for 10k cycles, NUM_DIR=8 -> invariants always hold.
//     Every pending request is served within NUM_DIR full rotations.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller.
//   phase_t    : phase encoding GREEN=0, YELLOW=1, ALLRED=2, WALK=3
//   dir_width(): width of an approach index, max(1, clog2(n))
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_WALK   = 2'd3
    } phase_t;

    function automatic int dir_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational cyclic-priority picker for the next approach to serve.
//   veh_pend : latched per-approach vehicle requests
//   dir      : approach currently (or most recently) served
//   next_dir : SKIP_EMPTY=0 -> (dir+1) mod NUM_DIR
//              SKIP_EMPTY=1 -> first pending approach in the order
//                              dir+1, dir+2, ..., dir (current one last);
//                              (dir+1) mod NUM_DIR when nothing is pending
module traffic_rr_pick #(
    parameter int NUM_DIR    = 2,
    parameter int DIR_W      = 1,
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic [NUM_DIR-1:0] veh_pend,
    input  logic [DIR_W-1:0]   dir,
    output logic [DIR_W-1:0]   next_dir
);

    logic [15:0] vp16;
    logic [3:0]  cand;
    logic        found;

    always_comb begin
        vp16     = 16'(veh_pend);
        cand     = 4'd0;
        found    = 1'b0;
        next_dir = DIR_W'((int'(dir) + 1) % NUM_DIR);
        if (SKIP_EMPTY) begin
            // Offsets 1..NUM_DIR: offset NUM_DIR wraps back to dir itself,
            // so the current approach is only picked if nothing else waits.
            for (int i = 1; i <= NUM_DIR; i++) begin
                cand = 4'((int'(dir) + i) % NUM_DIR);
                if (!found && vp16[cand]) begin
                    found    = 1'b1;
                    next_dir = DIR_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic signal controller: GREEN -> YELLOW -> ALLRED per
// approach, with a latched pedestrian WALK phase after ALLRED, optional
// skipping of idle approaches and a run/freeze enable.
//   clk, rst   : clock, synchronous active-high reset (overrides en)
//   en         : 1 = run, 0 = freeze every register (requests not latched)
//   veh_req    : per-approach vehicle sensors (synchronised)
//   ped_req    : pedestrian button (synchronised, a pulse suffices)
//   green      : one-hot, active approach during GREEN
//   yellow     : one-hot, active approach during YELLOW
//   red        : ~(green | yellow)
//   walk       : 1 during WALK only
//   phase      : current phase code (traffic_pkg::phase_t)
//   active_dir : active approach index
// Handshake: none; requests are level inputs latched into sticky pending
// bits while en=1 and consumed when served.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 4,
    parameter bit SKIP_EMPTY = 1'b0,
    parameter int CNT_W      = 8,
    localparam int DIR_W     = dir_width(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_DIR-1:0] veh_req,
    input  logic               ped_req,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] red,
    output logic               walk,
    output logic [1:0]         phase,
    output logic [DIR_W-1:0]   active_dir
);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("traffic_phase_ctrl: NUM_DIR must be in 2..8");
    end
    if (GREEN_CYC < 1 || GREEN_CYC > CNT_SPAN || YELLOW_CYC < 1 || YELLOW_CYC > CNT_SPAN ||
        ALLRED_CYC < 1 || ALLRED_CYC > CNT_SPAN || WALK_CYC < 1 || WALK_CYC > CNT_SPAN) begin : g_bad_cyc
        $error("traffic_phase_ctrl: every *_CYC must be in 1..2**CNT_W");
    end

    // Terminal counts; a duration of 2**CNT_W wraps to all-ones, which is
    // exactly the last value the counter reaches.
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_CYC - 1);

    function automatic logic [NUM_DIR-1:0] dir_mask(input logic [DIR_W-1:0] d);
        return {{(NUM_DIR-1){1'b0}}, 1'b1} << d;
    endfunction

    phase_t             phase_q, phase_n;
    logic [DIR_W-1:0]   dir_q, dir_n, next_dir;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_last;
    logic               ped_pend, ped_n;
    logic [NUM_DIR-1:0] veh_pend, veh_n;
    logic [NUM_DIR-1:0] green_n, yellow_n;

    traffic_rr_pick #(
        .NUM_DIR   (NUM_DIR),
        .DIR_W     (DIR_W),
        .SKIP_EMPTY(SKIP_EMPTY)
    ) u_pick (
        .veh_pend(veh_pend),
        .dir     (dir_q),
        .next_dir(next_dir)
    );

    always_comb begin
        unique case (phase_q)
            PH_GREEN:  cnt_last = G_LAST;
            PH_YELLOW: cnt_last = Y_LAST;
            PH_ALLRED: cnt_last = A_LAST;
            PH_WALK:   cnt_last = W_LAST;
        endcase
    end

    always_comb begin
        phase_n = phase_q;
        dir_n   = dir_q;
        cnt_n   = cnt_q;
        ped_n   = ped_pend;
        veh_n   = veh_pend;
        if (en) begin
            veh_n = veh_pend | veh_req;
            ped_n = ped_pend | ped_req;
            if (cnt_q == cnt_last) begin
                cnt_n = '0;
                unique case (phase_q)
                    PH_GREEN:  phase_n = PH_YELLOW;
                    PH_YELLOW: phase_n = PH_ALLRED;
                    PH_ALLRED: begin
                        if (ped_pend) begin
                            phase_n = PH_WALK;
                            ped_n   = 1'b0;          // clear beats a same-cycle press
                        end else begin
                            phase_n = PH_GREEN;
                            dir_n   = next_dir;
                            veh_n   = veh_n & ~dir_mask(next_dir);
                        end
                    end
                    PH_WALK: begin                   // no second ALLRED after WALK
                        phase_n = PH_GREEN;
                        dir_n   = next_dir;
                        veh_n   = veh_n & ~dir_mask(next_dir);
                    end
                endcase
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end
        green_n  = (phase_n == PH_GREEN)  ? dir_mask(dir_n) : '0;
        yellow_n = (phase_n == PH_YELLOW) ? dir_mask(dir_n) : '0;
    end

    // Lamp outputs are registered from the next-state decode so they change
    // on the same edge as phase/dir and never see the inputs combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_GREEN;
            dir_q    <= '0;
            cnt_q    <= '0;
            ped_pend <= 1'b0;
            veh_pend <= '0;
            green    <= {{(NUM_DIR-1){1'b0}}, 1'b1};
            yellow   <= '0;
            red      <= ~{{(NUM_DIR-1){1'b0}}, 1'b1};
            walk     <= 1'b0;
        end else begin
            phase_q  <= phase_n;
            dir_q    <= dir_n;
            cnt_q    <= cnt_n;
            ped_pend <= ped_n;
            veh_pend <= veh_n;
            green    <= green_n;
            yellow   <= yellow_n;
            red      <= ~(green_n | yellow_n);
            walk     <= (phase_n == PH_WALK);
        end
    end

    assign phase      = phase_q;
    assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: three instances (2 dirs plain, 4 dirs skip,
// 8 dirs skip) checked every cycle against a phase-level model, plus
// hand-computed literal points that pin both the DUT and the model.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic [2:0] rst_v, en_v, pr_v;
    logic [7:0] vr_v [3];

    logic [1:0] g0, y0, r0;
    logic [3:0] g1, y1, r1;
    logic [7:0] g2, y2, r2;
    logic [0:0] ad0;
    logic [1:0] ad1;
    logic [2:0] ad2;
    logic [2:0] w_a;
    logic [1:0] ph_a [3];
    logic [7:0] g_a [3], y_a [3], r_a [3], ad_a [3];

    int nchk = 0;
    int nfail = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_ctrl u0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .veh_req(vr_v[0][1:0]), .ped_req(pr_v[0]),
        .green(g0), .yellow(y0), .red(r0), .walk(w_a[0]), .phase(ph_a[0]), .active_dir(ad0));
    traffic_phase_ctrl #(.NUM_DIR(4), .SKIP_EMPTY(1'b1)) u1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .veh_req(vr_v[1][3:0]), .ped_req(pr_v[1]),
        .green(g1), .yellow(y1), .red(r1), .walk(w_a[1]), .phase(ph_a[1]), .active_dir(ad1));
    traffic_phase_ctrl #(.NUM_DIR(8), .SKIP_EMPTY(1'b1)) u2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .veh_req(vr_v[2]), .ped_req(pr_v[2]),
        .green(g2), .yellow(y2), .red(r2), .walk(w_a[2]), .phase(ph_a[2]), .active_dir(ad2));

    assign g_a[0] = 8'(g0);  assign y_a[0] = 8'(y0);  assign r_a[0] = 8'(r0);  assign ad_a[0] = 8'(ad0);
    assign g_a[1] = 8'(g1);  assign y_a[1] = 8'(y1);  assign r_a[1] = 8'(r1);  assign ad_a[1] = 8'(ad1);
    assign g_a[2] = g2;      assign y_a[2] = y2;      assign r_a[2] = r2;      assign ad_a[2] = 8'(ad2);

    // ---------------- model ----------------
    typedef struct {
        int         ph;    // 0 green, 1 yellow, 2 all-red, 3 walk
        int         dir;
        int         t;     // cycles already spent in this phase
        logic [7:0] vp;
        logic       pp;
    } m_t;

    m_t m [3];
    m_t nm;
    int age_v [3][8];
    int age_p [3];

    function automatic int ndir(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 8;
    endfunction

    function automatic bit skp(input int k);
        return k != 0;
    endfunction

    function automatic int dur(input int ph);
        case (ph)
            0: return 8;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    // Longest wait: NUM_DIR full rotations, each at most NUM_DIR*(8+2+1+4).
    function automatic int bound(input int k);
        return ndir(k) * ndir(k) * 15;
    endfunction

    function automatic logic [7:0] nmask(input int n);
        return 8'((1 << n) - 1);
    endfunction

    function automatic m_t m_step(input m_t s, input int n, input bit sk, input logic r,
                                  input logic e, input logic [7:0] vr, input logic p);
        m_t o;
        int nx;
        o = s;
        if (r) begin
            o.ph = 0; o.dir = 0; o.t = 0; o.vp = '0; o.pp = 1'b0;
            return o;
        end
        if (!e) return o;
        o.vp = s.vp | (vr & nmask(n));
        o.pp = s.pp | p;
        if (s.t + 1 < dur(s.ph)) begin
            o.t = s.t + 1;
        end else begin
            o.t = 0;
            if (s.ph == 0) o.ph = 1;
            else if (s.ph == 1) o.ph = 2;
            else if (s.ph == 2 && s.pp) begin
                o.ph = 3;
                o.pp = 1'b0;
            end else begin
                nx = (s.dir + 1) % n;
                // Walk the search order backwards so the nearest pending wins.
                if (sk)
                    for (int i = n; i >= 1; i--)
                        if (((s.vp >> ((s.dir + i) % n)) & 8'd1) != 8'd0) nx = (s.dir + i) % n;
                o.ph  = 0;
                o.dir = nx;
                o.vp  = o.vp & ~(8'd1 << nx);
            end
        end
        return o;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm_s, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm_s, act, exp, $time);
        end
    endtask

    task automatic check_le(input string nm_s, input int act, input int lim);
        nchk++;
        if (act > lim) begin
            nfail++;
            $display("FAIL %s: got %0d expected <= %0d (t=%0t)", nm_s, act, lim, $time);
        end
    endtask

    task automatic lit(input string nm_s, input int k, input int eph, input int edir);
        check({nm_s, "_phase"}, int'(ph_a[k]), eph);
        check({nm_s, "_dir"}, int'(ad_a[k]), edir);
        check({nm_s, "_model_phase"}, m[k].ph, eph);
        check({nm_s, "_model_dir"}, m[k].dir, edir);
    endtask

    task automatic lamps(input string nm_s, input int k, input int eg, input int ey, input int ew);
        check({nm_s, "_green"}, int'(g_a[k]), eg);
        check({nm_s, "_yellow"}, int'(y_a[k]), ey);
        check({nm_s, "_walk"}, int'(w_a[k]), ew);
    endtask

    // Model update at the active edge, plus request-service latency tracking.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            nm = m_step(m[k], ndir(k), skp(k), rst_v[k], en_v[k], vr_v[k], pr_v[k]);
            if (rst_v[k]) begin
                for (int d = 0; d < 8; d++) age_v[k][d] = 0;
                age_p[k] = 0;
            end else if (en_v[k]) begin
                for (int d = 0; d < ndir(k); d++) begin
                    if (m[k].vp[d[2:0]] && !nm.vp[d[2:0]]) begin
                        check_le($sformatf("u%0d_veh%0d_wait", k, d), age_v[k][d], bound(k));
                        age_v[k][d] = 0;
                    end
                    if (nm.vp[d[2:0]]) age_v[k][d]++;
                end
                if (m[k].pp && !nm.pp) begin
                    check_le($sformatf("u%0d_ped_wait", k), age_p[k], bound(k));
                    age_p[k] = 0;
                end
                if (nm.pp) age_p[k]++;
            end
            m[k] = nm;
        end
    end

    // Per-cycle comparison against the model and the safety invariants.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 3; k++) begin
                logic [7:0] eg, ey, mk;
                mk = nmask(ndir(k));
                eg = (m[k].ph == 0) ? 8'(1 << m[k].dir) : 8'd0;
                ey = (m[k].ph == 1) ? 8'(1 << m[k].dir) : 8'd0;
                check($sformatf("u%0d_green", k), int'(g_a[k]), int'(eg));
                check($sformatf("u%0d_yellow", k), int'(y_a[k]), int'(ey));
                check($sformatf("u%0d_red", k), int'(r_a[k]), int'(~(eg | ey) & mk));
                check($sformatf("u%0d_walk", k), int'(w_a[k]), (m[k].ph == 3) ? 1 : 0);
                check($sformatf("u%0d_phase", k), int'(ph_a[k]), m[k].ph);
                check($sformatf("u%0d_active_dir", k), int'(ad_a[k]), m[k].dir);
                check_le($sformatf("u%0d_inv_onehot", k), $countones(g_a[k] | y_a[k]), 1);
                check($sformatf("u%0d_inv_walk_dark", k), (w_a[k] && (g_a[k] | y_a[k]) != 8'd0) ? 1 : 0, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b0;
            en_v[k]  = 1'b1;
            pr_v[k]  = 1'b0;
            vr_v[k]  = 8'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge just before "cycle 0".
    task automatic do_reset();
        idle_inputs();
        rst_v = 3'b111;
        tick();
        rst_v = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        @(negedge clk);
        do_reset();
        cmp_on = 1'b1;

        // Free run on u0; skip-empty ordering on u1.
        for (int c = 0; c <= 46; c++) begin
            idle_inputs();
            if (c == 2)  vr_v[1][2] = 1'b1;
            if (c == 25) vr_v[1][2] = 1'b1;
            if (c == 35) vr_v[1][0] = 1'b1;
            case (c)
                0:  begin lit("a_c0", 0, 0, 0); lamps("a_c0", 0, 1, 0, 0); lit("a_c0_u1", 1, 0, 0); end
                7:  lit("a_c7", 0, 0, 0);
                8:  begin lit("a_c8", 0, 1, 0); lamps("a_c8", 0, 0, 1, 0); end
                9:  lit("a_c9", 0, 1, 0);
                10: begin lit("a_c10", 0, 2, 0); lamps("a_c10", 0, 0, 0, 0); end
                11: begin lit("a_c11", 0, 0, 1); lamps("a_c11", 0, 2, 0, 0); lit("a_c11_u1", 1, 0, 2); lamps("a_c11_u1", 1, 4, 0, 0); end
                21: begin lit("a_c21", 0, 2, 1); lit("a_c21_u1", 1, 2, 2); end
                22: begin lit("a_c22", 0, 0, 0); lit("a_c22_u1", 1, 0, 3); end
                33: lit("a_c33_u1", 1, 0, 2);
                44: begin lit("a_c44", 0, 0, 0); lit("a_c44_u1", 1, 0, 0); end
                default: ;
            endcase
            tick();
        end

        // Pedestrian WALK, including a press during WALK itself.
        do_reset();
        for (int c = 0; c <= 31; c++) begin
            idle_inputs();
            if (c == 3 || c == 12) pr_v[0] = 1'b1;
            case (c)
                10: lit("b_c10", 0, 2, 0);
                11: begin lit("b_c11", 0, 3, 0); lamps("b_c11", 0, 0, 0, 1); check("b_c11_red", int'(r_a[0]), 3); end
                14: lit("b_c14", 0, 3, 0);
                15: begin lit("b_c15", 0, 0, 1); lamps("b_c15", 0, 2, 0, 0); end
                25: lit("b_c25", 0, 2, 1);
                26: begin lit("b_c26", 0, 3, 1); lamps("b_c26", 0, 0, 0, 1); end
                29: lit("b_c29", 0, 3, 1);
                30: lit("b_c30", 0, 0, 0);
                default: ;
            endcase
            tick();
        end

        // Freeze across the GREEN->YELLOW boundary; press while frozen is ignored.
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            idle_inputs();
            if (c >= 8 && c <= 12) en_v[0] = 1'b0;
            if (c == 10) pr_v[0] = 1'b1;
            case (c)
                8:  lit("c_c8", 0, 1, 0);
                12: begin lit("c_c12", 0, 1, 0); lamps("c_c12", 0, 0, 1, 0); end
                13: lit("c_c13", 0, 1, 0);
                14: lit("c_c14", 0, 1, 0);
                15: lit("c_c15", 0, 2, 0);
                16: begin lit("c_c16", 0, 0, 1); lamps("c_c16", 0, 2, 0, 0); end
                default: ;
            endcase
            tick();
        end

        // Reset in the middle of WALK with a pending press.
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            idle_inputs();
            if (c == 3 || c == 12) pr_v[0] = 1'b1;
            if (c == 13) rst_v[0] = 1'b1;
            case (c)
                13: lit("d_c13", 0, 3, 0);
                14: begin lit("d_c14", 0, 0, 0); lamps("d_c14", 0, 1, 0, 0); end
                24: lit("d_c24", 0, 2, 0);
                25: begin lit("d_c25", 0, 0, 1); lamps("d_c25", 0, 2, 0, 0); end
                default: ;
            endcase
            tick();
        end

        // Random requests and enable on every instance.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 3; k++) begin
                rst_v[k] = 1'b0;
                en_v[k]  = ($urandom_range(0, 9) != 0);
                pr_v[k]  = ($urandom_range(0, 39) == 0);
                vr_v[k]  = 8'd0;
                for (int d = 0; d < ndir(k); d++)
                    vr_v[k][d[2:0]] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end

        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < ndir(k); d++)
                check_le($sformatf("u%0d_veh%0d_wait_end", k, d), age_v[k][d], bound(k));
            check_le($sformatf("u%0d_ped_wait_end", k), age_p[k], bound(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
